// File: rtl/ysyx_23060184_lsu_axi_master.sv
// AXI-lite master between the MEM stage and the data SRAM: one outstanding load/store.
// Define MISALIGN_CHECK_EN to fail word-crossing half/word accesses without any bus transaction.
module ysyx_23060184_lsu_axi_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = 8,
    parameter int unsigned RESP_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  aready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [RESP_WIDTH-1:0] rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [RESP_WIDTH-1:0] bresp,
    input  logic                  bvalid,
    output logic                  bready
);
    localparam int unsigned LANES = 4;

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_e;

    state_e                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic [1:0]            off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [DATA_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic [DATA_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                  awvalid_q, awvalid_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_err_q, resp_err_d;

    logic                  misalign_c;
    logic [LANES-1:0]      lane_mask_c;
    logic [LANES-1:0]      lane_strb_c;
    logic [DATA_WIDTH-1:0] load_lanes_c;
    logic [DATA_WIDTH-1:0] load_ext_c;

`ifdef MISALIGN_CHECK_EN
    assign misalign_c = ((req_size == 2'd1) && (req_addr[1:0] == 2'd3))
                     || (req_size[1] && (req_addr[1:0] != 2'd0));
`else
    assign misalign_c = 1'b0;
`endif

    // Store byte-enables; lanes shifted past byte 3 fall off the 4-bit mask.
    always_comb begin
        unique case (req_size)
            2'd0:    lane_mask_c = 4'b0001;
            2'd1:    lane_mask_c = 4'b0011;
            default: lane_mask_c = 4'b1111;
        endcase
        lane_strb_c = lane_mask_c << req_addr[1:0];
    end

    // Load lane alignment and sign/zero extension.
    always_comb begin
        load_lanes_c = rdata >> {off_q, 3'b000};
        unique case (size_q)
            2'd0: load_ext_c = unsigned_q ? DATA_WIDTH'(load_lanes_c[7:0])
                             : {{(DATA_WIDTH-8){load_lanes_c[7]}}, load_lanes_c[7:0]};
            2'd1: load_ext_c = unsigned_q ? DATA_WIDTH'(load_lanes_c[15:0])
                             : {{(DATA_WIDTH-16){load_lanes_c[15]}}, load_lanes_c[15:0]};
            default: load_ext_c = load_lanes_c;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        off_d        = off_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awaddr_d     = awaddr_q;
        awvalid_d    = awvalid_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_ready_d  = 1'b0;
                    off_d        = req_addr[1:0];
                    size_d       = req_size;
                    unsigned_d   = req_unsigned;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                    if (misalign_c) begin
                        resp_err_d   = 1'b1;
                        resp_valid_d = 1'b1;
                        state_d      = DONE;
                    end else if (req_wen) begin
                        awaddr_d  = {req_addr[DATA_WIDTH-1:2], 2'b00};
                        wdata_d   = req_wdata << {req_addr[1:0], 3'b000};
                        wstrb_d   = STRB_WIDTH'(lane_strb_c);
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = {req_addr[DATA_WIDTH-1:2], 2'b00};
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (aready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    rready_d     = 1'b0;
                    resp_rdata_d = load_ext_c;
                    resp_err_d   = (rresp != '0);
                    resp_valid_d = 1'b1;
                    state_d      = DONE;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; B is opened once both are gone.
                awvalid_d = awvalid_q && !awready;
                wvalid_d  = wvalid_q && !wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    bready_d     = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = (bresp != '0);
                    resp_valid_d = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            off_q        <= 2'd0;
            size_q       <= 2'd0;
            unsigned_q   <= 1'b0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awaddr_q     <= '0;
            awvalid_q    <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            off_q        <= off_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awaddr_q     <= awaddr_d;
            awvalid_q    <= awvalid_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign araddr     = araddr_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;
    assign awaddr     = awaddr_q;
    assign awvalid    = awvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign wvalid     = wvalid_q;
    assign bready     = bready_q;

endmodule
